// File: rtl/key_cmd_sched.sv
// Command scheduler: latches debounced key requests and dispatches one flash
// command at a time (BE > SE > RD) with start/done handshake, timeout and idle gap.
module key_cmd_sched #(
  parameter logic [31:0] TIMEOUT_MAX = 32'd2_499_999_999,
  parameter logic [7:0]  GAP_MAX     = 8'd9
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_be,
  input  logic       key_se,
  input  logic       key_rd,
  input  logic       cmd_done,
  output logic       cmd_start,
  output logic [1:0] cmd_sel,
  output logic       busy,
  output logic [2:0] pend,
  output logic       done_flag,
  output logic       timeout_flag
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam logic [1:0] SEL_BE = 2'b00;
  localparam logic [1:0] SEL_SE = 2'b01;
  localparam logic [1:0] SEL_RD = 2'b10;

  state_t      r_state;
  logic [2:0]  r_pend;
  logic [1:0]  r_cmd_sel;
  logic [31:0] r_timer;
  logic [7:0]  r_gap;
  logic        r_cmd_start;
  logic        r_busy;
  logic        r_done_flag;
  logic        r_timeout_flag;

  state_t      w_state_nxt;
  logic [2:0]  w_pend_nxt;
  logic [2:0]  w_clr;
  logic [1:0]  w_sel_nxt;
  logic [31:0] w_timer_nxt;
  logic [7:0]  w_gap_nxt;
  logic        w_start_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        w_to_nxt;

  function automatic logic [1:0] prio_sel(input logic [2:0] p);
    logic [1:0] s;
    if (p[0]) begin
      s = SEL_BE;
    end else if (p[1]) begin
      s = SEL_SE;
    end else begin
      s = SEL_RD;
    end
    return s;
  endfunction

  function automatic logic [2:0] sel_mask(input logic [1:0] s);
    logic [2:0] m;
    case (s)
      SEL_BE:  m = 3'b001;
      SEL_SE:  m = 3'b010;
      SEL_RD:  m = 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  // Next-state and next-output logic for the dispatch FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_cmd_sel;
    w_clr       = 3'b000;
    w_timer_nxt = r_timer;
    w_gap_nxt   = r_gap;
    w_start_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_to_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend != 3'b000) begin
          w_state_nxt = S_START;
          w_sel_nxt   = prio_sel(r_pend);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        w_start_nxt = 1'b1;
        w_clr       = sel_mask(r_cmd_sel);
        w_timer_nxt = 32'd0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Completion takes precedence over a coincident timeout.
        if (cmd_done) begin
          w_done_nxt  = 1'b1;
          w_gap_nxt   = 8'd0;
          w_state_nxt = S_GAP;
        end else if (r_timer == TIMEOUT_MAX) begin
          w_to_nxt    = 1'b1;
          w_gap_nxt   = 8'd0;
          w_state_nxt = S_GAP;
        end else if (r_timer != 32'hFFFF_FFFF) begin
          w_timer_nxt = r_timer + 32'd1;
        end else begin
          w_timer_nxt = r_timer;
        end
      end
      S_GAP: begin
        if (r_gap == GAP_MAX) begin
          w_gap_nxt   = 8'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt   = r_gap + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // A key pulse coinciding with the clear re-arms the request.
    w_pend_nxt = (r_pend & ~w_clr) | {key_rd, key_se, key_be};
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state        <= S_IDLE;
      r_pend         <= 3'b000;
      r_cmd_sel      <= 2'b00;
      r_timer        <= 32'd0;
      r_gap          <= 8'd0;
      r_cmd_start    <= 1'b0;
      r_busy         <= 1'b0;
      r_done_flag    <= 1'b0;
      r_timeout_flag <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_pend         <= w_pend_nxt;
      r_cmd_sel      <= w_sel_nxt;
      r_timer        <= w_timer_nxt;
      r_gap          <= w_gap_nxt;
      r_cmd_start    <= w_start_nxt;
      r_busy         <= w_busy_nxt;
      r_done_flag    <= w_done_nxt;
      r_timeout_flag <= w_to_nxt;
    end
  end

  assign cmd_start    = r_cmd_start;
  assign cmd_sel      = r_cmd_sel;
  assign busy         = r_busy;
  assign pend         = r_pend;
  assign done_flag    = r_done_flag;
  assign timeout_flag = r_timeout_flag;

endmodule

// File: tb/tb_key_cmd_sched.sv
// Directed bench for key_cmd_sched with a shortened timeout (TIMEOUT_MAX = 20).
module tb_key_cmd_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_be = 1'b0;
  logic       key_se = 1'b0;
  logic       key_rd = 1'b0;
  logic       cmd_done = 1'b0;
  logic       cmd_start;
  logic [1:0] cmd_sel;
  logic       busy;
  logic [2:0] pend;
  logic       done_flag;
  logic       timeout_flag;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  key_cmd_sched #(
    .TIMEOUT_MAX(32'd20),
    .GAP_MAX    (8'd9)
  ) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .key_be      (key_be),
    .key_se      (key_se),
    .key_rd      (key_rd),
    .cmd_done    (cmd_done),
    .cmd_start   (cmd_start),
    .cmd_sel     (cmd_sel),
    .busy        (busy),
    .pend        (pend),
    .done_flag   (done_flag),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag, input int limit);
    int k = 0;
    while (cmd_start !== 1'b1 && k < limit) begin
      tick();
      k++;
    end
    chk({tag, "_start_seen"}, {31'd0, cmd_start}, 32'd1);
  endtask

  task automatic pulse_done();
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
  endtask

  initial begin
    int t0;
    int n_start;
    int n_act;

    // Reset state
    repeat (3) tick();
    chk("rst_start", {31'd0, cmd_start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pend", {29'd0, pend}, 32'd0);
    chk("rst_sel", {30'd0, cmd_sel}, 32'd0);
    chk("rst_flags", {30'd0, done_flag, timeout_flag}, 32'd0);
    rst_n = 1'b1;
    repeat (6) tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Single SE request with normal completion
    key_se = 1'b1;
    tick();
    key_se = 1'b0;
    chk("se_pend_set", {29'd0, pend}, 32'h2);
    chk("se_busy_before_start", {31'd0, busy}, 32'd0);
    tick();
    chk("se_busy_start_state", {31'd0, busy}, 32'd1);
    chk("se_no_start_yet", {31'd0, cmd_start}, 32'd0);
    tick();
    chk("se_cmd_start", {31'd0, cmd_start}, 32'd1);
    chk("se_cmd_sel", {30'd0, cmd_sel}, 32'h1);
    chk("se_pend_clear", {29'd0, pend}, 32'd0);
    tick();
    chk("se_start_one_cycle", {31'd0, cmd_start}, 32'd0);
    repeat (4) tick();
    pulse_done();
    chk("se_done_flag", {31'd0, done_flag}, 32'd1);
    chk("se_no_timeout", {31'd0, timeout_flag}, 32'd0);
    chk("se_busy_gap", {31'd0, busy}, 32'd1);
    tick();
    chk("se_done_one_cycle", {31'd0, done_flag}, 32'd0);
    pulse_done();
    chk("gap_done_ignored", {30'd0, done_flag, timeout_flag}, 32'd0);
    chk("gap_busy_held", {31'd0, busy}, 32'd1);
    repeat (7) tick();
    chk("gap_last_cycle_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("gap_end_idle", {31'd0, busy}, 32'd0);

    // cmd_done while idle
    pulse_done();
    chk("idle_done_ignored", {30'd0, done_flag, timeout_flag}, 32'd0);
    chk("idle_done_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("idle_done_no_start", {31'd0, cmd_start}, 32'd0);

    // Three simultaneous requests, minimum-length waits
    key_be = 1'b1; key_se = 1'b1; key_rd = 1'b1;
    tick();
    key_be = 1'b0; key_se = 1'b0; key_rd = 1'b0;
    chk("all_pend", {29'd0, pend}, 32'h7);
    wait_start("prio_be", 10);
    chk("prio_be_sel", {30'd0, cmd_sel}, 32'h0);
    chk("prio_be_pend", {29'd0, pend}, 32'h6);
    t0 = cyc;
    pulse_done();
    wait_start("prio_se", 30);
    chk("prio_se_sel", {30'd0, cmd_sel}, 32'h1);
    chk("prio_se_pend", {29'd0, pend}, 32'h4);
    chk("prio_se_spacing", cyc - t0, 32'd13);
    t0 = cyc;
    pulse_done();
    wait_start("prio_rd", 30);
    chk("prio_rd_sel", {30'd0, cmd_sel}, 32'h2);
    chk("prio_rd_pend", {29'd0, pend}, 32'h0);
    chk("prio_rd_spacing", cyc - t0, 32'd13);
    pulse_done();
    n_start = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cmd_start) n_start++;
    end
    chk("prio_exactly_three", n_start, 32'd0);
    chk("prio_idle", {31'd0, busy}, 32'd0);

    // Repeated BE pulses absorbed; BE during WAIT re-dispatches
    key_rd = 1'b1;
    tick();
    key_rd = 1'b0;
    wait_start("abs_rd", 10);
    chk("abs_rd_sel", {30'd0, cmd_sel}, 32'h2);
    tick();
    key_be = 1'b1; tick(); key_be = 1'b0;
    tick();
    key_be = 1'b1; tick(); key_be = 1'b0;
    key_be = 1'b1; tick(); key_be = 1'b0;
    chk("abs_pend_once", {29'd0, pend}, 32'h1);
    chk("abs_still_wait", {31'd0, busy}, 32'd1);
    pulse_done();
    wait_start("abs_be1", 30);
    chk("abs_be1_sel", {30'd0, cmd_sel}, 32'h0);
    chk("abs_be1_pend", {29'd0, pend}, 32'h0);
    tick();
    key_be = 1'b1; tick(); key_be = 1'b0;
    chk("abs_be_rearm", {29'd0, pend}, 32'h1);
    pulse_done();
    wait_start("abs_be2", 30);
    chk("abs_be2_sel", {30'd0, cmd_sel}, 32'h0);
    chk("abs_be2_pend", {29'd0, pend}, 32'h0);
    pulse_done();
    n_start = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cmd_start) n_start++;
    end
    chk("abs_no_third_be", n_start, 32'd0);

    // Timeout with no completion
    key_se = 1'b1; tick(); key_se = 1'b0;
    wait_start("to", 10);
    repeat (20) tick();
    chk("to_not_yet", {31'd0, timeout_flag}, 32'd0);
    chk("to_busy_wait", {31'd0, busy}, 32'd1);
    tick();
    chk("to_flag", {31'd0, timeout_flag}, 32'd1);
    chk("to_no_done", {31'd0, done_flag}, 32'd0);
    tick();
    chk("to_one_cycle", {31'd0, timeout_flag}, 32'd0);
    repeat (9) tick();
    chk("to_back_idle", {31'd0, busy}, 32'd0);

    // Completion on the timeout cycle wins
    key_se = 1'b1; tick(); key_se = 1'b0;
    wait_start("tie", 10);
    repeat (20) tick();
    pulse_done();
    chk("tie_done", {31'd0, done_flag}, 32'd1);
    chk("tie_no_timeout", {31'd0, timeout_flag}, 32'd0);
    tick();
    chk("tie_flags_clear", {30'd0, done_flag, timeout_flag}, 32'd0);
    repeat (10) tick();
    chk("tie_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-WAIT with RD pending
    key_se = 1'b1; tick(); key_se = 1'b0;
    wait_start("ar", 10);
    tick();
    key_rd = 1'b1; tick(); key_rd = 1'b0;
    chk("ar_pend_rd", {29'd0, pend}, 32'h4);
    chk("ar_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk("ar_async_busy", {31'd0, busy}, 32'd0);
    chk("ar_async_pend", {29'd0, pend}, 32'd0);
    chk("ar_async_outs", {27'd0, cmd_start, cmd_sel, done_flag, timeout_flag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_start = 0;
    n_act = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cmd_start) n_start++;
      if (busy || done_flag || timeout_flag || (pend != 3'b000)) n_act++;
    end
    chk("ar_no_dispatch", n_start, 32'd0);
    chk("ar_quiet", n_act, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_cmd_sched.md
Name: key_cmd_sched

Overview:
Command scheduler between the debounced key front-ends and the SPI flash operation engine. Three `key_flag` single-cycle pulses request bulk erase, sector erase and read. The block latches pending requests and dispatches one command at a time under fixed priority, using a start/done handshake. It enforces a minimum idle gap between commands and aborts a hung command with a timeout.

Parameters:
- TIMEOUT_MAX, 32'd2_499_999_999, last cycle count of the WAIT state before abort (50 s at 50 MHz; covers bulk-erase worst case).
- GAP_MAX, 8'd9, last count of the inter-command gap; the gap lasts GAP_MAX+1 cycles (chip-select-high time margin).

Ports:
- sys_clk  in  1  system clock (50 MHz).
- sys_rst_n  in  1  asynchronous active-low reset.
- key_be  in  1  bulk-erase request, 1-cycle pulse from the debouncer.
- key_se  in  1  sector-erase request, 1-cycle pulse.
- key_rd  in  1  read request, 1-cycle pulse.
- cmd_done  in  1  engine completion, 1-cycle pulse.
- cmd_start  out  1  dispatch strobe, 1-cycle pulse.
- cmd_sel  out  2  command code: 2'b00 BE, 2'b01 SE, 2'b10 RD. Stable from cmd_start until the next dispatch.
- busy  out  1  high whenever state != IDLE.
- pend  out  3  pending request bits {rd,se,be}.
- done_flag  out  1  1-cycle pulse on a normal completion.
- timeout_flag  out  1  1-cycle pulse on an abort.

Behaviour:
- One clock domain. Reset is asynchronous and active-low on sys_rst_n, clocked by sys_clk.
- Reset values: state=IDLE; cmd_start, busy, done_flag, timeout_flag = 0; cmd_sel=2'b00; pend=3'b000; timer=0; gap counter=0.
- Request latch:
  - A key pulse sets its pend bit in the cycle after the pulse.
  - A repeated pulse for a bit already pending is absorbed; there is no queue depth beyond 1 per command.
- FSM states: IDLE, START, WAIT, GAP. All outputs are registered.
- IDLE:
  - If pend != 0, go to START next cycle.
  - In the same edge, register cmd_sel from the highest-priority pend bit: BE > SE > RD.
  - Otherwise stay in IDLE.
- START (exactly 1 cycle):
  - cmd_start=1.
  - Clear the dispatched pend bit.
  - Clear the timer.
  - Go to WAIT.
  - If a key pulse for that same command arrives in this cycle, the set wins and the bit stays pending as a new request.
- WAIT:
  - The timer increments by 1 per cycle.
  - If cmd_done=1: done_flag=1 next cycle, go to GAP.
  - Else if timer==TIMEOUT_MAX: timeout_flag=1 next cycle, go to GAP.
  - If cmd_done and the timeout coincide, done wins and no timeout_flag is raised.
  - The timer saturates; it does not wrap.
- GAP:
  - The gap counter counts 0..GAP_MAX, then the block returns to IDLE.
  - The gap counter is cleared on entry.
- cmd_done outside WAIT is ignored, with no flag and no state change.
- Key pulses are latched in every state, including during WAIT and GAP.
- Minimum spacing between consecutive cmd_start pulses = 1 (START) + 1 (min WAIT) + GAP_MAX+1 (GAP) + 1 (IDLE) cycles.
- busy rises the cycle after pend first becomes non-zero, i.e. when entering START. It falls on entry to IDLE.
- Reset asserted mid-operation:
  - Immediately returns all state to the reset values.
  - Pending requests are discarded.
  - No done_flag or timeout_flag is emitted.
- Arithmetic:
  - The timer is 32 bits and is compared with == against TIMEOUT_MAX.
  - The gap counter is 8 bits.
  - Both are unsigned, with no overflow by construction.

Test Plan:
- Reset, then key_se pulse at cycle 10 → pend=3'b010 at cycle 11; cmd_start at cycle 13 with cmd_sel=2'b01 and pend=0; cmd_done 5 cycles later → done_flag 1 cycle later; busy low after GAP_MAX+1 gap cycles.
- key_rd, key_se and key_be pulsed in the same cycle → dispatch order BE(00), SE(01), RD(10); exactly three cmd_start pulses, each separated by at least GAP_MAX+4 cycles.
- key_be pulsed 3 times while BE is pending (before START) → a single BE dispatch. A further key_be pulse during WAIT → a second BE dispatch after the gap.
- TIMEOUT_MAX=32'd20 and cmd_done never asserted → timeout_flag pulse 21 cycles after cmd_start, done_flag stays 0, block returns to IDLE. Repeat with cmd_done on the timeout cycle → done_flag only.
- cmd_done pulsed while IDLE and while in GAP → no flag, state unchanged.
- sys_rst_n low mid-WAIT with pend=3'b100 → all outputs 0 asynchronously; after release, no dispatch occurs without new key pulses.
